// File: rtl/lut_layer_scheduler.sv
// ---------------------------------------------------------------------------
// lut_layer_scheduler
//   Time-multiplexed evaluator for one sparse LogicNets layer. A single shared
//   LUT-neuron engine computes N_NEURONS outputs, one neuron per cycle. Each
//   neuron's fan-in feature indices (connection table) and its truth table
//   live in distributed RAM, programmed through the config port while idle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   cfg_we     config write strobe
//   cfg_sel    0 = truth table {neuron, lut_addr}, 1 = connection table
//              {neuron, slot} in the LSBs of cfg_addr
//   cfg_addr   config address
//   cfg_wdata  truth value (OUT_W LSBs) or feature index
//   cfg_err    one-cycle pulse when a config write is rejected
//   in_valid / in_ready / in_data     input feature vector handshake
//   out_valid / out_ready / out_data  result vector handshake
//   busy       high while evaluating or holding a result
//
// Optional build macro SCHED_PERF_CNT_EN adds output inf_count[15:0], a
// saturating count of completed output handshakes.
// ---------------------------------------------------------------------------
module lut_layer_scheduler #(
    parameter int N_IN      = 8,
    parameter int IN_W      = 2,
    parameter int FANIN     = 2,
    parameter int N_NEURONS = 8,
    parameter int OUT_W     = 2,
    localparam int A        = FANIN * IN_W,
    localparam int NW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int SW       = (FANIN > 1) ? $clog2(FANIN) : 1,
    localparam int FW       = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WD       = (OUT_W > FW) ? OUT_W : FW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic                       cfg_sel,
    input  logic [NW+A-1:0]            cfg_addr,
    input  logic [WD-1:0]              cfg_wdata,
    output logic                       cfg_err,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*IN_W-1:0]       in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_NEURONS*OUT_W-1:0] out_data,
    output logic                       busy
`ifdef SCHED_PERF_CNT_EN
   ,output logic [15:0]                inf_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t                  state;
    logic [NW-1:0]           cnt;
    logic [N_IN*IN_W-1:0]    in_reg;

    // Table RAMs are sized to the full address space so {neuron, slot} and
    // {neuron, lut_addr} can index them directly; they carry no reset.
    logic [FW-1:0]           conn_mem  [2**(NW+SW)];
    logic [OUT_W-1:0]        truth_mem [2**(NW+A)];

    logic                    in_fire;
    logic                    cfg_ok;
    logic [A-1:0]            lut_addr;
    logic [OUT_W-1:0]        lut_q;

    assign in_fire = in_valid && in_ready;
    // The input handshake has priority over a same-cycle config write.
    assign cfg_ok  = cfg_we && (state == S_IDLE) && !in_fire;

    // Gather the fan-in features of the current neuron; slot 0 lands in the
    // LSBs. An index outside the feature range reads feature 0.
    always_comb begin
        logic [FW-1:0] idx;
        lut_addr = '0;
        idx      = '0;
        for (int unsigned s = 0; s < FANIN; s++) begin
            idx = conn_mem[{cnt, SW'(s)}];
            if (32'(idx) < 32'(N_IN))
                lut_addr[s*IN_W +: IN_W] = in_reg[idx*IN_W +: IN_W];
            else
                lut_addr[s*IN_W +: IN_W] = in_reg[0 +: IN_W];
        end
    end

    assign lut_q = truth_mem[{cnt, lut_addr}];

    always_ff @(posedge clk) begin
        if (rst && cfg_ok) begin
            if (cfg_sel)
                conn_mem[cfg_addr[NW+SW-1:0]] <= cfg_wdata[FW-1:0];
            else
                truth_mem[cfg_addr] <= cfg_wdata[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            cnt       <= '0;
            in_reg    <= '0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        in_reg   <= in_data;
                        cnt      <= '0;
                        state    <= S_EVAL;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_EVAL: begin
                    out_data[cnt*OUT_W +: OUT_W] <= lut_q;
                    cnt <= cnt + 1'b1;
                    if (cnt == NW'(N_NEURONS - 1)) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            inf_count <= '0;
        else if (out_valid && out_ready && (inf_count != 16'hFFFF))
            inf_count <= inf_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lut_layer_scheduler
//   Directed bench for lut_layer_scheduler with default parameters
//   (8 features x 2 bits, fan-in 2, 8 neurons x 2-bit outputs).
// ---------------------------------------------------------------------------
module tb_lut_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic        cfg_sel;
    logic [6:0]  cfg_addr;
    logic [2:0]  cfg_wdata;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
`ifdef SCHED_PERF_CNT_EN
    logic [15:0] inf_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] m_conn  [8][2];
    logic [1:0] m_truth [8][16];

    always #5 clk = ~clk;

    lut_layer_scheduler #(
        .N_IN(8), .IN_W(2), .FANIN(2), .N_NEURONS(8), .OUT_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
`ifdef SCHED_PERF_CNT_EN
       ,.inf_count(inf_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  a;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            a = {v[m_conn[n][1]*2 +: 2], v[m_conn[n][0]*2 +: 2]};
            r[n*2 +: 2] = m_truth[n][a];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [6:0] addr, input logic [2:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic set_conn(input int n, input int s, input logic [2:0] idx);
        logic [2:0] nn;
        nn = 3'(n);
        cfg_write(1'b1, {3'b000, nn, 1'(s)}, idx);
        check("cfg_conn_accept", cfg_err, 0);
        m_conn[n][s] = idx;
    endtask

    task automatic set_truth(input int n, input int a, input logic [1:0] val);
        logic [2:0] nn;
        logic [3:0] aa;
        nn = 3'(n); aa = 4'(a);
        cfg_write(1'b0, {nn, aa}, {1'b0, val});
        check("cfg_truth_accept", cfg_err, 0);
        m_truth[n][a] = val;
    endtask

    // Identity tables: neuron output = lut_addr[1:0] (the slot-0 feature).
    task automatic program_identity;
        logic [3:0] aa;
        for (int n = 0; n < 8; n++)
            for (int a = 0; a < 16; a++) begin
                aa = 4'(a);
                set_truth(n, a, aa[1:0]);
            end
    endtask

    task automatic wait_ready;
        int w = 0;
        while (!in_ready && w < 20) begin tick; w++; end
        check("in_ready_before_accept", in_ready, 1);
    endtask

    // Accept one vector, check latency and result, optionally stall the
    // output for 'hold' cycles, then complete the output handshake.
    task automatic run_vec(input logic [15:0] v, input int hold, output logic [15:0] res);
        int lat;
        logic [15:0] exp;
        wait_ready;
        exp = model(v);
        in_valid = 1'b1; in_data = v;
        tick;
        in_valid = 1'b0; in_data = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin tick; lat++; end
        check("latency", lat, 8);
        check("out_data", out_data, exp);
        check("busy_done", busy, 1);
        res = out_data;
        for (int i = 0; i < hold; i++) begin
            tick;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data_stable", out_data, exp);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_out_data_held", out_data, exp);
    endtask

    task automatic drain_output;
        int w = 0;
        while (!out_valid && w < 20) begin tick; w++; end
        check("drain_out_valid", out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] res;
        logic [15:0] v;

        rst = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick; tick;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst = 1'b1;
        tick;

        // Connection table: neuron 0 reads {3,5}, neuron n reads {n, 7-n}.
        set_conn(0, 0, 3'd3);
        set_conn(0, 1, 3'd5);
        for (int n = 1; n < 8; n++) begin
            set_conn(n, 0, 3'(n));
            set_conn(n, 1, 3'(7 - n));
        end
        program_identity;
        set_truth(0, 9, 2'b10);

        // feature3 = 01, feature5 = 10 -> neuron 0 address 4'b1001 -> 2'b10.
        v = 16'h0840;
        run_vec(v, 0, res);
        check("single_n0", res[1:0], 2'b10);

        // Backpressure, then the next vector is accepted right away.
        run_vec(16'h1B6C, 5, res);
        run_vec(16'hE4A1, 0, res);

        // Write during EVAL is rejected.
        wait_ready;
        in_valid = 1'b1; in_data = v;
        tick;
        in_valid = 1'b0;
        tick; tick;
        cfg_write(1'b0, {3'd0, 4'd9}, 3'd3);
        check("eval_cfg_err", cfg_err, 1);
        tick;
        check("eval_cfg_err_pulse", cfg_err, 0);
        drain_output;
        check("eval_reject_data", out_data[1:0], 2'b10);
        out_ready = 1'b1; tick; out_ready = 1'b0;

        // Write colliding with an input handshake in IDLE is rejected.
        in_valid = 1'b1; in_data = v;
        cfg_write(1'b0, {3'd0, 4'd9}, 3'd1);
        in_valid = 1'b0;
        check("idle_cfg_err", cfg_err, 1);
        check("idle_handshake_won", busy, 1);
        tick;
        check("idle_cfg_err_pulse", cfg_err, 0);
        drain_output;
        check("idle_reject_data", out_data, model(v));
        check("idle_reject_n0", out_data[1:0], 2'b10);
        out_ready = 1'b1; tick; out_ready = 1'b0;

        // Full layer with pure identity tables and random vectors.
        set_truth(0, 9, 2'b01);
        for (int i = 0; i < 100; i++)
            run_vec(16'($urandom), 0, res);

        // Asynchronous reset mid-EVAL; tables survive.
        wait_ready;
        in_valid = 1'b1; in_data = 16'hFFFF;
        tick;
        in_valid = 1'b0;
        tick; tick;
        #2 rst = 1'b0;
        #1;
        check("async_in_ready", in_ready, 1);
        check("async_out_valid", out_valid, 0);
        check("async_out_data", out_data, 0);
        check("async_busy", busy, 0);
        tick;
        rst = 1'b1;
        tick;
        run_vec(16'h9C35, 0, res);

`ifdef SCHED_PERF_CNT_EN
        rst = 1'b0; tick; rst = 1'b1; tick;
        check("perf_rst", inf_count, 0);
        for (int i = 0; i < 3; i++) run_vec(16'($urandom), 0, res);
        check("perf_three", inf_count, 3);
        force dut.inf_count = 16'hFFFE;
        tick;
        release dut.inf_count;
        for (int i = 0; i < 3; i++) run_vec(16'($urandom), 0, res);
        check("perf_saturate", inf_count, 16'hFFFF);
        #2 rst = 1'b0;
        #1;
        check("perf_reset", inf_count, 0);
        tick;
        rst = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
